// File: rtl/lsu_mem_responder_pkg.sv
// Purpose: shared types and memory-map constants for the LSU data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT_A,
    S_BEAT_B,
    S_LAST,
    S_RESP
  } rsp_state_e;

  localparam int          DEFAULT_DEPTH_WORDS = 512;
  localparam logic [31:0] DMEM_BASE           = 32'h0000_0000;
  localparam logic [31:0] DMEM_LAST           = DMEM_BASE + 32'(4 * DEFAULT_DEPTH_WORDS) - 32'd1;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input lsu_size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sp_bram_bmask.sv
// Purpose: single-port synchronous-read RAM, 32-bit words with per-byte write mask.
// Latency: read data valid the cycle after i_en; writes land on the same edge.
// Backpressure: none, accepts an access every cycle.
// Ports: i_clk clock; i_en access enable; i_we byte-lane write mask;
//        i_addr word address; i_wdata write data; o_rdata registered read data
//        (old contents on a simultaneous read/write).
module sp_bram_bmask #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // No reset on the array so synthesis can map it onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      o_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Purpose: LSU data-memory slave; splits word-crossing accesses, extends loads, flags range errors.
// Latency: first o_rsp_valid cycle after accept edge T is T+3 single beat, T+4 crossing, T+1 error.
// Backpressure: one transaction in flight; o_req_ready only in IDLE, response held until i_rsp_ready.
// Ports: i_clk, i_reset (sync, active-high); request i_req_valid/o_req_ready with
//        i_req_addr, i_req_wdata, i_req_size, i_req_wren, i_req_signed;
//        response o_rsp_valid/i_rsp_ready with o_rsp_rdata, o_rsp_err.
module lsu_mem_responder
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_wren,
  input  logic        i_req_signed,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LAST_BYTE = 33'(4 * DEPTH_WORDS) - 33'd1;

  rsp_state_e state, state_nxt;

  // Latched request
  logic [AW-1:0] word_q;
  logic [1:0]    off_q;
  lsu_size_e     size_q;
  logic          wren_q, signed_q, cross_q;
  logic [31:0]   wdata_q;

  // Datapath
  logic [31:0]   low_word;
  logic [31:0]   ram_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic [3:0]    ram_we;

  // Request decode (combinational, used on the accept edge)
  lsu_size_e   req_size;
  logic [2:0]  req_nbytes;
  logic [32:0] req_last;
  logic        req_err, req_cross, accept;

  always_comb begin
    case (i_req_size)
      2'b00:   req_size = SZ_BYTE;
      2'b01:   req_size = SZ_HALF;
      default: req_size = SZ_WORD;
    endcase
  end

  assign req_nbytes = size_bytes(req_size);
  // 33-bit sum so addresses near 0xFFFF_FFFF cannot wrap back into range.
  assign req_last   = {1'b0, i_req_addr} + 33'(req_nbytes) - 33'd1;
  assign req_err    = req_last > LAST_BYTE;
  assign req_cross  = ({1'b0, i_req_addr[1:0]} + req_nbytes) > 3'd4;
  assign accept     = i_req_valid && o_req_ready;

  assign o_req_ready = (state == S_IDLE);
  assign o_rsp_valid = (state == S_RESP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q   <= '0;
      off_q    <= '0;
      size_q   <= SZ_BYTE;
      wren_q   <= 1'b0;
      signed_q <= 1'b0;
      cross_q  <= 1'b0;
      wdata_q  <= '0;
    end else if (accept) begin
      word_q   <= i_req_addr[AW+1:2];
      off_q    <= i_req_addr[1:0];
      size_q   <= req_size;
      wren_q   <= i_req_wren;
      signed_q <= i_req_signed;
      cross_q  <= req_cross;
      wdata_q  <= i_req_wdata;
    end
  end

  // Lane steering: the access is viewed as an 8-byte window over two
  // consecutive words; bytes 0..3 go to beat A, 4..7 to beat B.
  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] wdata64;

  always_comb begin
    case (size_q)
      SZ_BYTE: base_mask = 4'b0001;
      SZ_HALF: base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  assign mask8   = {4'b0000, base_mask} << off_q;
  assign wdata64 = {32'd0, wdata_q} << {off_q, 3'b000};

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = word_q;
    ram_wdata = wdata64[31:0];
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = req_err ? S_RESP : S_BEAT_A;
      end
      S_BEAT_A: begin
        ram_en    = 1'b1;
        ram_we    = wren_q ? mask8[3:0] : 4'b0000;
        state_nxt = cross_q ? S_BEAT_B : S_LAST;
      end
      S_BEAT_B: begin
        ram_en    = 1'b1;
        ram_addr  = word_q + AW'(1);
        ram_wdata = wdata64[63:32];
        ram_we    = wren_q ? mask8[7:4] : 4'b0000;
        state_nxt = S_LAST;
      end
      S_LAST: state_nxt = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A beat coinciding with reset is dropped, so an interrupted crossing
    // store never writes its second word.
    if (i_reset) begin
      ram_en = 1'b0;
      ram_we = 4'b0000;
    end
  end

  sp_bram_bmask #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (ram_en),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  // Beat A's read word arrives while in BEAT_B; keep it for assembly.
  always_ff @(posedge i_clk) begin
    if (state == S_BEAT_B) low_word <= ram_rdata;
  end

  // Load assembly: pick four bytes starting at the offset from the
  // two-word window, then extend by size.
  logic [63:0] rd_cat;
  logic [31:0] rd_aligned, ld_ext;

  assign rd_cat = cross_q ? {ram_rdata, low_word} : {ram_rdata, ram_rdata};

  always_comb begin
    rd_aligned = '0;
    for (int i = 0; i < 4; i++) begin
      rd_aligned[8*i +: 8] = rd_cat[8*(int'(off_q) + i) +: 8];
    end
    case (size_q)
      SZ_BYTE: ld_ext = {{24{signed_q & rd_aligned[7]}},  rd_aligned[7:0]};
      SZ_HALF: ld_ext = {{16{signed_q & rd_aligned[15]}}, rd_aligned[15:0]};
      default: ld_ext = rd_aligned;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (accept && req_err) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b1;
    end else if (state == S_LAST) begin
      o_rsp_rdata <= wren_q ? 32'd0 : ld_ext;
      o_rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Purpose: self-checking bench for lsu_mem_responder against a byte-array memory model.
// Latency: expected response cycle derived from access size/offset/range.
// Backpressure: exercises held responses and reset during a crossing store.
module tb_lsu_mem_responder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [1:0]  i_req_size;
  logic        i_req_wren;
  logic        i_req_signed;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  int n_chk = 0;
  int n_err = 0;

  // Byte-addressed reference memory covering the whole RAM range.
  logic [7:0] mdl [0:2047];

  lsu_mem_responder #(.DEPTH_WORDS(512)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_size   (i_req_size),
    .i_req_wren   (i_req_wren),
    .i_req_signed (i_req_signed),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_err(input logic [31:0] a, input int n);
    logic [63:0] last;
    last = {32'd0, a} + 64'(n) - 64'd1;
    return last > 64'd2047;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
    if (sg && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sg && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // One full transaction; expectations come from the model, which is then
  // updated for successful stores. hold = cycles of response backpressure.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic wr, input logic sg,
                      input int hold, output logic [31:0] rd);
    int n, lat, exp_lat;
    logic exp_er;
    logic [31:0] exp_rd;
    n       = nbytes(sz);
    exp_er  = m_err(addr, n);
    exp_lat = exp_er ? 1 : ((int'(addr[1:0]) + n > 4) ? 4 : 3);
    exp_rd  = (exp_er || wr) ? 32'd0 : m_load(addr, n, sg);

    chk($sformatf("%s/req_ready", tag), 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    i_req_size   = sz;
    i_req_wren   = wr;
    i_req_signed = sg;
    i_rsp_ready  = (hold == 0);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk($sformatf("%s/rsp_valid", tag), 32'(o_rsp_valid), 32'd1);
    chk($sformatf("%s/latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s/rdata", tag), o_rsp_rdata, exp_rd);
    chk($sformatf("%s/err", tag), 32'(o_rsp_err), 32'(exp_er));
    rd = o_rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      chk($sformatf("%s/hold_valid", tag), 32'(o_rsp_valid), 32'd1);
      chk($sformatf("%s/hold_ready", tag), 32'(o_req_ready), 32'd0);
      chk($sformatf("%s/hold_rdata", tag), o_rsp_rdata, exp_rd);
      chk($sformatf("%s/hold_err", tag), 32'(o_rsp_err), 32'(exp_er));
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    chk($sformatf("%s/back_idle", tag), {30'd0, o_req_ready, o_rsp_valid}, 32'd2);
    if (wr && !exp_er) begin
      for (int i = 0; i < n; i++) mdl[int'(addr) + i] = wd[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ra;
    logic [1:0]  rs;

    i_reset      = 1'b1;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    i_req_size   = 2'b00;
    i_req_wren   = 1'b0;
    i_req_signed = 1'b0;
    i_rsp_ready  = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("reset/req_ready", 32'(o_req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset/rsp_rdata", o_rsp_rdata, 32'd0);
    chk("reset/rsp_err",   32'(o_rsp_err),  32'd0);

    // Fill the whole RAM so every later load has a known expectation.
    for (int w = 0; w < 512; w++) xfer("init", 32'(4 * w), $urandom, 2'b10, 1'b1, 1'b0, 0, rd);

    // Aligned word store/load
    xfer("sw_010", 32'h010, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 0, rd);
    xfer("lw_010", 32'h010, 32'h0,        2'b10, 1'b0, 1'b0, 0, rd);
    chk("lw_010/const", rd, 32'hDEADBEEF);

    // Crossing word store at offset 1
    xfer("sw_021", 32'h021, 32'h11223344, 2'b10, 1'b1, 1'b0, 0, rd);
    xfer("lbu_021", 32'h021, 0, 2'b00, 1'b0, 1'b0, 0, rd); chk("lbu_021/const", rd, 32'h44);
    xfer("lbu_022", 32'h022, 0, 2'b00, 1'b0, 1'b0, 0, rd); chk("lbu_022/const", rd, 32'h33);
    xfer("lbu_023", 32'h023, 0, 2'b00, 1'b0, 1'b0, 0, rd); chk("lbu_023/const", rd, 32'h22);
    xfer("lbu_024", 32'h024, 0, 2'b00, 1'b0, 1'b0, 0, rd); chk("lbu_024/const", rd, 32'h11);
    xfer("lw_021",  32'h021, 0, 2'b10, 1'b0, 1'b0, 0, rd); chk("lw_021/const",  rd, 32'h11223344);

    // Byte store; upper wdata bits must be ignored
    xfer("sb_033", 32'h033, 32'h12345680, 2'b00, 1'b1, 1'b0, 0, rd);
    xfer("lb_033",  32'h033, 0, 2'b00, 1'b0, 1'b1, 0, rd); chk("lb_033/const",  rd, 32'hFFFFFF80);
    xfer("lbu_033", 32'h033, 0, 2'b00, 1'b0, 1'b0, 0, rd); chk("lbu_033/const", rd, 32'h00000080);
    xfer("lw_030",  32'h030, 0, 2'b10, 1'b0, 1'b0, 0, rd);

    // Halfwords: crossing at offset 3, single beat at offset 1
    xfer("sh_043", 32'h043, 32'h0000BEEF, 2'b01, 1'b1, 1'b0, 0, rd);
    xfer("lh_043", 32'h043, 0, 2'b01, 1'b0, 1'b1, 0, rd); chk("lh_043/const", rd, 32'hFFFFBEEF);
    xfer("sh_041", 32'h041, 32'hFFFFA55A, 2'b01, 1'b1, 1'b0, 0, rd);
    xfer("lhu_041", 32'h041, 0, 2'b01, 1'b0, 1'b0, 0, rd); chk("lhu_041/const", rd, 32'h0000A55A);
    xfer("lbu_040", 32'h040, 0, 2'b00, 1'b0, 1'b0, 0, rd);
    xfer("lw_044",  32'h044, 0, 2'b10, 1'b0, 1'b0, 0, rd);

    // Size code 11 behaves as a word
    xfer("s11_062", 32'h062, 32'hCAFEF00D, 2'b11, 1'b1, 1'b0, 0, rd);
    xfer("lw_062",  32'h062, 0, 2'b10, 1'b0, 1'b0, 0, rd); chk("lw_062/const", rd, 32'hCAFEF00D);

    // Range boundary
    xfer("lw_7FD",  32'h7FD, 0, 2'b10, 1'b0, 1'b0, 0, rd);
    xfer("sw_800",  32'h800, 32'h55555555, 2'b10, 1'b1, 1'b0, 0, rd);
    xfer("sw_7FD",  32'h7FD, 32'h66666666, 2'b10, 1'b1, 1'b0, 0, rd);
    xfer("lw_7FC",  32'h7FC, 0, 2'b10, 1'b0, 1'b0, 0, rd);
    xfer("lb_7FF",  32'h7FF, 0, 2'b00, 1'b0, 1'b1, 0, rd);
    xfer("lh_7FF",  32'h7FF, 0, 2'b01, 1'b0, 1'b0, 0, rd);
    xfer("lb_top",  32'hFFFFFFFF, 0, 2'b00, 1'b0, 1'b0, 0, rd);

    // Response backpressure
    xfer("hold_lw", 32'h010, 0, 2'b10, 1'b0, 1'b0, 5, rd);
    xfer("hold_err", 32'h900, 0, 2'b01, 1'b0, 1'b0, 3, rd);

    // Reset while a crossing store is in its second beat
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h051;
    i_req_wdata  = 32'hAABBCCDD;
    i_req_size   = 2'b10;
    i_req_wren   = 1'b1;
    i_req_signed = 1'b0;
    i_rsp_ready  = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("rst_b/req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_b/rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_b/rsp_rdata", o_rsp_rdata, 32'd0);
    @(posedge i_clk); #1;
    chk("rst_b/stay_idle", {30'd0, o_req_ready, o_rsp_valid}, 32'd2);
    // First beat was issued before reset, so bytes 0x51..0x53 hold new data.
    mdl[32'h051] = 8'hDD;
    mdl[32'h052] = 8'hCC;
    mdl[32'h053] = 8'hBB;
    xfer("rst_b/lw_050", 32'h050, 0, 2'b10, 1'b0, 1'b0, 0, rd);
    xfer("rst_b/lw_054", 32'h054, 0, 2'b10, 1'b0, 1'b0, 0, rd);

    // Randomized mix, including some out-of-range addresses
    for (int t = 0; t < 300; t++) begin
      ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 2063));
      rs = 2'($urandom_range(0, 3));
      xfer($sformatf("rnd%0d", t), ra, $urandom, rs, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 2), rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
